// File: rtl/mem_probe_if.sv
// mem_probe_if: bus bundle between mem_probe and its surroundings.
//   Memory read port : mem_en, mem_addr (probe -> memory), mem_rdata (memory -> probe)
//   Dump stream      : dump_valid, dump_data, dump_index (probe -> consumer),
//                      dump_ready (consumer -> probe)
// Modports: master = probe side, slave = memory/consumer side.
interface mem_probe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;

  modport master (
    output mem_en, mem_addr, dump_valid, dump_data, dump_index,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_en, mem_addr, dump_valid, dump_data, dump_index,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/mem_probe.sv
// mem_probe: post-run memory probe for KGPminiRISC.
// Arms on start, waits for halt (or a TIMEOUT-cycle budget), then reads
// NUM_WORDS words from BASE_ADDR onward and streams them over a valid/ready port.
// Ports:
//   clk, rst (sync, active-low), start (arm pulse), halt (core halted level)
//   bus       : mem_probe_if.master (memory read port + dump stream)
//   sum       : signed running sum of accepted words (DATA_W+8 bits)
//   busy/done : activity / dump complete
//   timed_out : dump was forced by the timeout
// Optional feature macro MEM_PROBE_CHECKSUM_EN: enables the sum accumulator,
// parameter EXPECT_SUM and output match. Undefined: sum is tied to 0.
module mem_probe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 10,
  parameter int TIMEOUT   = 15000,
  parameter int RD_LAT    = 1
`ifdef MEM_PROBE_CHECKSUM_EN
  ,
  parameter logic [DATA_W+7:0] EXPECT_SUM = '0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  mem_probe_if.master       bus,
  output logic [DATA_W+7:0] sum,
  output logic              busy,
  output logic              done,
  output logic              timed_out
`ifdef MEM_PROBE_CHECKSUM_EN
  ,
  output logic              match
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ISSUE, S_LAT, S_OUT, S_DONE
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [1:0]        r_lat;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_to;
  logic              w_arm;
  logic              w_to_set;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_arm       = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_arm       = 1'b1;
          w_idx_nxt   = '0;
        end
      end
      S_WAIT: begin
        // Timeout is judged on the post-increment count so the forced ISSUE
        // lands exactly TIMEOUT cycles after start; halt has priority.
        if (halt) begin
          w_state_nxt = S_ISSUE;
        end else if (w_cnt_inc >= TO_LAST) begin
          w_state_nxt = S_ISSUE;
          w_to_set    = 1'b1;
        end
      end
      S_ISSUE: w_state_nxt = S_LAT;
      S_LAT: begin
        if (r_lat == LAT_LAST) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.dump_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_arm) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_to_set) r_to <= 1'b1;
      if (r_state == S_ISSUE) r_lat <= '0;
      else if (r_state == S_LAT) r_lat <= r_lat + 1'b1;
      if (r_state == S_LAT && r_lat == LAT_LAST) r_data <= bus.mem_rdata;
      // Address is registered on entry to ISSUE so it holds afterwards.
      if (w_state_nxt == S_ISSUE) r_addr <= ADDR_W'(BASE_ADDR) + w_idx_nxt;
    end
  end

  assign bus.mem_en     = (r_state == S_ISSUE);
  assign bus.mem_addr   = r_addr;
  assign bus.dump_valid = (r_state == S_OUT);
  assign bus.dump_data  = r_data;
  assign bus.dump_index = r_idx;
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign timed_out      = r_to;

`ifdef MEM_PROBE_CHECKSUM_EN
  logic [DATA_W+7:0] r_sum;
  logic              w_accept;

  assign w_accept = (r_state == S_OUT) && bus.dump_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_arm) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + {{8{r_data[DATA_W-1]}}, r_data};
    end
  end

  assign sum   = r_sum;
  assign match = (r_state == S_DONE) && (r_sum == EXPECT_SUM);
`else
  assign sum = '0;
`endif

endmodule

// File: tb/tb_mem_probe.sv
// tb_mem_probe: two probe instances (RD_LAT=1 window 0..9, RD_LAT=2 window
// wrapping at 1022..1), each with a behavioural memory and a timeline model.
module tb_mem_probe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];
  logic start [2];
  logic halt  [2];
  logic ready [2];

  mem_probe_if #(.DATA_W(32), .ADDR_W(10)) bus0 ();
  mem_probe_if #(.DATA_W(32), .ADDR_W(10)) bus1 ();

  logic        men [2];
  logic [9:0]  madr [2];
  logic        dv [2];
  logic [31:0] dd [2];
  logic [9:0]  di [2];
  logic [39:0] sm [2];
  logic        bsy [2];
  logic        dn [2];
  logic        tmo [2];
`ifdef MEM_PROBE_CHECKSUM_EN
  logic        mt [2];
`endif

  mem_probe #(
    .DATA_W(32), .ADDR_W(10), .BASE_ADDR(0), .NUM_WORDS(10), .TIMEOUT(20), .RD_LAT(1)
`ifdef MEM_PROBE_CHECKSUM_EN
    , .EXPECT_SUM(40'd30)
`endif
  ) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .start(start[0]), .halt(halt[0]), .bus(bus0),
    .sum(sm[0]), .busy(bsy[0]), .done(dn[0]), .timed_out(tmo[0])
`ifdef MEM_PROBE_CHECKSUM_EN
    , .match(mt[0])
`endif
  );

  mem_probe #(
    .DATA_W(32), .ADDR_W(10), .BASE_ADDR(1022), .NUM_WORDS(4), .TIMEOUT(20), .RD_LAT(2)
`ifdef MEM_PROBE_CHECKSUM_EN
    , .EXPECT_SUM(40'd30)
`endif
  ) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .start(start[1]), .halt(halt[1]), .bus(bus1),
    .sum(sm[1]), .busy(bsy[1]), .done(dn[1]), .timed_out(tmo[1])
`ifdef MEM_PROBE_CHECKSUM_EN
    , .match(mt[1])
`endif
  );

  assign men[0] = bus0.mem_en;      assign men[1] = bus1.mem_en;
  assign madr[0] = bus0.mem_addr;   assign madr[1] = bus1.mem_addr;
  assign dv[0] = bus0.dump_valid;   assign dv[1] = bus1.dump_valid;
  assign dd[0] = bus0.dump_data;    assign dd[1] = bus1.dump_data;
  assign di[0] = bus0.dump_index;   assign di[1] = bus1.dump_index;
  assign bus0.dump_ready = ready[0];
  assign bus1.dump_ready = ready[1];

  // Behavioural memories; data is only meaningful RD_LAT cycles after mem_en.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] p0a, p1a, p1b;
  always @(posedge clk) begin
    p0a <= bus0.mem_en ? mem0[bus0.mem_addr] : 32'hDEAD_BEEF;
    p1a <= bus1.mem_en ? mem1[bus1.mem_addr] : 32'hDEAD_BEEF;
    p1b <= p1a;
  end
  assign bus0.mem_rdata = p0a;
  assign bus1.mem_rdata = p1b;

  function automatic int p_base(int g); return (g == 0) ? 0 : 1022; endfunction
  function automatic int p_nw(int g);   return (g == 0) ? 10 : 4;   endfunction
  function automatic int p_rl(int g);   return (g == 0) ? 1 : 2;    endfunction
  localparam int TO = 20;

  function automatic logic [31:0] rd(int g, int i);
    int a = (p_base(g) + i) % 1024;
    return (g == 0) ? mem0[a] : mem1[a];
  endfunction

  // Controls written only by the stimulus process.
  int  exp_lat [2];
  int  exp_to  [2];
  bit  tag_a   [2];
  bit  chk_space [2];
  bit  chk_en = 0;
  bit  final_chk = 0;
  bit  rmode = 0;
  int  hangs = 0;
  int  stall [2];

  // Model and counters written only by the compare process.
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          m_phase [2] = '{0, 0};   // 0 idle, 1 running, 2 done
  bit          m_wait [2]  = '{0, 0};
  int          m_start [2] = '{0, 0};
  int          m_issue [2] = '{-1, -1};
  int          m_vfrom [2] = '{-1, -1};
  int          m_widx [2]  = '{0, 0};
  int          m_last [2]  = '{0, 0};
  bit          m_to [2]    = '{0, 0};
  bit          m_rstz [2]  = '{0, 0};
  logic [39:0] m_sum [2]   = '{40'd0, 40'd0};
  logic [31:0] m_hold [2]  = '{32'd0, 32'd0};
  int          alog1 [$];
  bit          final_done = 0;
  int          exp_a [4] = '{1022, 1023, 0, 1};

  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL dut%0d %s @cyc %0d: got %0h want %0h", g, nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        logic        exp_en, exp_v;
        logic [39:0] exp_sum;
        logic [31:0] wd;
        if (m_rstz[g]) begin
          chk(g, "rst_mem_addr", madr[g], 0);
          chk(g, "rst_dump_data", dd[g], 0);
          chk(g, "rst_dump_index", di[g], 0);
          m_rstz[g] = 1'b0;
        end
        exp_en = (m_issue[g] == cyc);
        exp_v  = (m_vfrom[g] >= 0) && (cyc >= m_vfrom[g]);
        wd     = rd(g, m_widx[g]);
        chk(g, "mem_en", men[g], exp_en);
        if (exp_en) begin
          chk(g, "mem_addr", madr[g], (p_base(g) + m_widx[g]) % 1024);
          if (g == 1) alog1.push_back(int'(madr[1]));
          if (m_widx[g] == 0 && exp_lat[g] >= 0) chk(g, "start_to_issue", cyc - m_start[g], exp_lat[g]);
          if (m_widx[g] == 0 && exp_to[g] >= 0) chk(g, "timed_out_at_issue", tmo[g], exp_to[g]);
        end
        chk(g, "dump_valid", dv[g], exp_v);
        if (exp_v) begin
          chk(g, "dump_data", dd[g], wd);
          chk(g, "dump_index", di[g], m_widx[g]);
        end
        if (m_phase[g] == 2) chk(g, "data_hold", dd[g], m_hold[g]);
        chk(g, "busy", bsy[g], m_phase[g] == 1);
        chk(g, "done", dn[g], m_phase[g] == 2);
        chk(g, "timed_out", tmo[g], m_to[g]);
`ifdef MEM_PROBE_CHECKSUM_EN
        exp_sum = m_sum[g];
        chk(g, "match", mt[g], (m_phase[g] == 2) && (m_sum[g] == 40'd30));
`else
        exp_sum = '0;
`endif
        chk(g, "sum", sm[g], exp_sum);

        if (!rst_n[g]) begin
          m_phase[g] = 0; m_wait[g] = 0; m_issue[g] = -1; m_vfrom[g] = -1;
          m_to[g] = 0; m_sum[g] = '0; m_hold[g] = '0; m_rstz[g] = 1'b1;
        end else begin
          case (m_phase[g])
            0, 2: begin
              if (start[g]) begin
                m_phase[g] = 1; m_wait[g] = 1; m_start[g] = cyc; m_widx[g] = 0;
                m_to[g] = 0; m_sum[g] = '0; m_issue[g] = -1; m_vfrom[g] = -1;
                if (g == 1) alog1.delete();
              end
            end
            default: begin
              if (m_wait[g]) begin
                if (halt[g] || (cyc - m_start[g] >= TO - 1)) begin
                  if (!halt[g]) m_to[g] = 1;
                  m_wait[g]  = 0;
                  m_issue[g] = cyc + 1;
                  m_vfrom[g] = cyc + 2 + p_rl(g);
                end
              end else if (exp_v && ready[g]) begin
                m_sum[g]  = m_sum[g] + {{8{wd[31]}}, wd};
                m_hold[g] = wd;
                if (chk_space[g] && m_widx[g] > 0) chk(g, "word_spacing", cyc - m_last[g], p_rl(g) + 2);
                m_last[g] = cyc;
                if (m_widx[g] == p_nw(g) - 1) begin
                  m_phase[g] = 2; m_issue[g] = -1; m_vfrom[g] = -1;
                  if (tag_a[g]) chk(g, "model_sum_30", m_sum[g], 30);
                  if (g == 1) begin
                    chk(g, "addr_count", alog1.size(), 4);
                    if (alog1.size() == 4)
                      for (int k = 0; k < 4; k++) chk(g, "addr_wrap", alog1[k], exp_a[k]);
                  end
                end else begin
                  m_widx[g]++;
                  m_issue[g] = cyc + 1;
                  m_vfrom[g] = cyc + 2 + p_rl(g);
                end
              end
            end
          endcase
        end
      end
      if (final_chk && !final_done) begin
        chk(0, "no_hang", hangs, 0);
        final_done = 1;
      end
    end
    cyc++;
  end

  task automatic step;
    @(posedge clk);
    #1;
    if (rmode) begin
      for (int g = 0; g < 2; g++) begin
        if (stall[g] > 0) begin
          ready[g] = 1'b0; stall[g]--;
        end else if ($urandom_range(0, 15) == 0) begin
          ready[g] = 1'b0; stall[g] = 6;   // 7-cycle stall
        end else begin
          ready[g] = ($urandom_range(0, 1) != 0);
        end
        start[g] = bsy[g] && ($urandom_range(0, 5) == 0);
      end
    end
  endtask

  task automatic arm(input logic [1:0] mask);
    for (int g = 0; g < 2; g++) start[g] = mask[g];
    step();
    start[0] = 1'b0; start[1] = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] mask, input int budget);
    int k = 0;
    while (!((!mask[0] || dn[0]) && (!mask[1] || dn[1])) && k < budget) begin
      step(); k++;
    end
    if (k >= budget) hangs++;
  endtask

  task automatic set_exp(input int lat, input int to_v);
    for (int g = 0; g < 2; g++) begin exp_lat[g] = lat; exp_to[g] = to_v; end
  endtask

  int da [10] = '{5, -3, 7, 0, 2, 9, -1, 4, 6, 1};

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; halt[g] = 1'b1; ready[g] = 1'b1;
      exp_lat[g] = -1; exp_to[g] = -1; tag_a[g] = 0; chk_space[g] = 0; stall[g] = 0;
    end
    for (int i = 0; i < 10; i++) mem0[i] = da[i];
    mem1[1022] = $urandom; mem1[1023] = $urandom; mem1[0] = $urandom; mem1[1] = $urandom;
    repeat (3) step();
    chk_en = 1;
    step();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    step();

    // Halt already high, consumer always ready.
    set_exp(2, 0);
    tag_a[0] = 1; chk_space[0] = 1; chk_space[1] = 1;
    arm(2'b11);
    wait_done(2'b11, 300);
    tag_a[0] = 0;

    // Timeout forces the dump.
    halt[0] = 1'b0; halt[1] = 1'b0;
    set_exp(20, 1);
    arm(2'b11);
    wait_done(2'b11, 600);

    // Halt arrives in the same cycle as the timeout: halt wins.
    halt[0] = 1'b0; halt[1] = 1'b0;
    set_exp(20, 0);
    arm(2'b11);
    repeat (18) step();
    halt[0] = 1'b1; halt[1] = 1'b1;
    wait_done(2'b11, 600);

    // Random back-pressure with stalls, random data, stray start pulses.
    chk_space[0] = 0; chk_space[1] = 0;
    set_exp(2, 0);
    for (int r = 0; r < 5; r++) begin
      if (r == 0) mem0[3] = 32'd1;
      else for (int i = 0; i < 10; i++) mem0[i] = $urandom;
      mem1[1022] = $urandom; mem1[1023] = $urandom; mem1[0] = $urandom; mem1[1] = $urandom;
      arm(2'b11);
      rmode = 1;
      wait_done(2'b11, 3000);
      rmode = 0;
      for (int g = 0; g < 2; g++) begin ready[g] = 1'b1; start[g] = 1'b0; stall[g] = 0; end
    end

    // Reset during the third word's OUT, then a clean full dump.
    for (int i = 0; i < 10; i++) mem0[i] = da[i];
    arm(2'b01);
    begin
      int k = 0;
      while (!(dv[0] && di[0] == 10'd2) && k < 200) begin step(); k++; end
      if (k >= 200) hangs++;
    end
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    tag_a[0] = 1;
    arm(2'b01);
    wait_done(2'b01, 300);

    final_chk = 1;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_probe.md
# mem_probe

Synthesizable post-run memory probe for KGPminiRISC. Arms on `start`, waits for the core's `halt` or a cycle timeout, then reads a window of data memory and streams it out word by word over a valid/ready port. Replaces fixed-delay, hierarchical memory peeking in benches with a parametrised, cycle-exact readout. It sits beside the datapath on the data-memory read port, which the core does not use once halted.

## Interface

Parameters:
- `DATA_W`, 32, memory word width
- `ADDR_W`, 10, memory address width
- `BASE_ADDR`, 0, first word address of the window
- `NUM_WORDS`, 10, words per dump; must be at least 1
- `TIMEOUT`, 15000, cycles to wait for `halt` before forcing the dump; must be at least 1
- `RD_LAT`, 1, memory read latency in cycles; legal values 1 or 2

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle arm pulse.
- `halt` in 1: core halted; level signal.
- `mem_en` out 1: memory read enable.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rdata` in DATA_W: memory read data.
- `dump_valid` out 1: `dump_data` and `dump_index` are valid.
- `dump_ready` in 1: consumer accepts the current word.
- `dump_data` out DATA_W: word read from memory.
- `dump_index` out ADDR_W: offset of the word within the window, starting at 0.
- `sum` out DATA_W+8: signed running sum of the words accepted so far.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `timed_out` out 1: the dump was forced by the timeout.

## Operation

States: IDLE, WAIT, ISSUE, LAT, OUT, DONE.
- IDLE: `start` moves to WAIT and clears the cycle counter, `sum`, `timed_out` and the word index.
- WAIT: the counter increments every cycle.
  - `halt`=1 goes to ISSUE.
  - Otherwise, when the counter reaches TIMEOUT-1, go to ISSUE and set `timed_out`.
  - If both happen in the same cycle, `halt` wins and `timed_out` stays 0.
- ISSUE: drive `mem_en`=1 and `mem_addr`=(BASE_ADDR+index) mod 2^ADDR_W for one cycle, then go to LAT.
- LAT: wait RD_LAT-1 further cycles, then capture `mem_rdata` into `dump_data` and go to OUT.
- OUT: `dump_valid`=1.
  - When `dump_ready`=1, the word is accepted and `sum` += sign-extended `dump_data`.
  - If index==NUM_WORDS-1, go to DONE. Otherwise increment the index and go to ISSUE.
- DONE: `done` stays 1 and `dump_data`/`sum` hold their values. `start` re-arms, following the same rule as IDLE.
- `start` in WAIT, ISSUE, LAT or OUT is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. `sum` wraps modulo 2^(DATA_W+8) in two's complement.

## Timing

- Reset values: all outputs are 0 and the state is IDLE.
- Reset applied mid-operation aborts within one cycle. No partial word is presented after reset.
- Latency from `start` to ISSUE: 2 cycles if `halt` is already high (one cycle in WAIT).
- Latency from ISSUE to the first `dump_valid`: RD_LAT+1 cycles.
- Per-word throughput with `dump_ready` held high: RD_LAT+2 cycles.
- While `dump_valid`=1 and `dump_ready`=0, `dump_data` and `dump_index` are stable. `dump_valid` never drops without an accept.
- `sum` updates on the clock edge after an accept, so it is visible in the same cycle the next ISSUE is driven.
- `mem_en` is high only in ISSUE; `mem_addr` holds its last value otherwise.
- `done` rises on the cycle after the final accept.

## Configuration

- `MEM_PROBE_CHECKSUM_EN` defined:
  - `sum` accumulates as described.
  - A parameter `EXPECT_SUM` (default 0) and an output `match` are added. `match`=1 in DONE iff `sum`==`EXPECT_SUM`, and is 0 in every other state.
- Not defined: `sum` is tied to 0, there is no accumulator logic, and `match`/`EXPECT_SUM` do not exist.

## Test plan

- Preload memory [0..9] with 5, -3, 7, 0, 2, 9, -1, 4, 6, 1. Hold `halt`=1 and `dump_ready`=1, then pulse `start`. Required: 10 words at indices 0..9 in order, `sum`=30, `done`=1, `timed_out`=0, and each word spaced RD_LAT+2 cycles apart.
- Set TIMEOUT=20 and keep `halt`=0. Required: ISSUE on cycle 20 after `start` and `timed_out`=1. Also drive `halt` and the timeout in the same cycle; required: `timed_out`=0.
- Toggle `dump_ready` randomly, including stalls of 7 cycles. Required: no word is lost or duplicated, and the data stays stable during stalls. Run with RD_LAT=1 and RD_LAT=2.
- Use BASE_ADDR=1022, NUM_WORDS=4, ADDR_W=10. Required: the addresses issued are 1022, 1023, 0, 1.
- Deassert `rst` for one cycle in the middle of the third word's OUT. Required: all outputs are 0 on the next cycle and the state is IDLE. A later `start` produces a full, correct dump.
- With `MEM_PROBE_CHECKSUM_EN` defined and EXPECT_SUM=30, run the first test: required `match`=1. Run again with one word changed: required `match`=0.
